alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- Decode/operand-issue stage sitting directly upstream of the 8-bit pipeline ALU.
- Accepts 16-bit instruction words over a valid/ready handshake and reads operands from an internal 8x8 register file.
- Drives the ALU operand (A, B) and opcode inputs from registers, then writes the ALU result back into the register file.
- Detects read-after-write hazards against in-flight ALU ops; resolves them by stall, or by stall plus forwarding.

Parameters:
- DW, 8, datapath width; must match ALU operand width.
- NREG, 8, number of architectural registers; register index width is log2(NREG) = 3.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction word present.
- in_instr  in  16  instruction: [15:13] op, [12:10] rd, [9:7] rs1, [6:4] rs2, [3:0] ignored.
- in_ready  out  1  stage accepts in_instr this cycle.
- alu_result  in  DW  ALU registered output (ALU out).
- A  out  DW  operand A to ALU, registered.
- B  out  DW  operand B to ALU, registered.
- alu_op  out  3  opcode to ALU instr, registered.
- illegal_flag  out  1  sticky; set on acceptance of a reserved op.
- dbg_addr  in  3  register file debug read index.
- dbg_data  out  DW  combinational read of rf[dbg_addr]; r0 reads 0.

Behaviour:
- Ops:
  - 000 NOP; 001 ADD; 010 SUB; 011 AND; 100 NOT (rs2 ignored, B driven 0).
  - 101/110/111 reserved: accepted, issued as NOP, illegal_flag <= 1.
  - ADD/SUB/AND/NOT write rd; NOP and reserved ops write nothing.
- r0 is hardwired 0: reads return 0; writes to rd=0 are discarded.
- Acceptance at edge k when in_valid & in_ready:
  - A, B, alu_op load at edge k.
  - The ALU registers the result at edge k+1; alu_result is valid during the cycle after edge k+1.
  - The stage writes rf[rd] <= alu_result at edge k+2.
- Internal pipeline tracking:
  - ex slot (ex_v, ex_rd) for the op issued at the last edge.
  - wb slot (wb_v, wb_rd), advanced from ex each edge.
  - A slot is valid only for writing ops with rd != 0.
- Bubble: when in_valid=0, or when in_ready=0, the edge loads alu_op <= 000; A and B hold their values; ex_v <= 0.
- Hazard: in_ready = !RST & !(ex_v & (rs1==ex_rd | (rs2==ex_rd & op uses rs2))), i.e. 1-cycle stall on a dependency on the immediately preceding op.
- Operand select priority for rsN != 0: wb match -> alu_result (forward, FWD_EN only); else rf[rsN].
- rf read/write same edge: the write lands at the edge; the read in the same cycle sees the old value unless forwarded.
- Back-to-back independent ops issue every cycle; max throughput is 1/cycle.
- Reset (synchronous): A=0, B=0, alu_op=000, all rf entries=0, ex_v=wb_v=0, illegal_flag=0, in_ready=0 while RST=1.
- Reset mid-operation: pending ex/wb writebacks are dropped and never written.
- The instruction held during RST is not accepted.
- in_valid with X on in_instr is not required to be handled.

Optional Feature:
- Macro: ALU_ISSUE_FWD_EN.
- Defined: wb-slot forwarding from alu_result is active; a dependency on the op one ahead costs 1 stall cycle; a dependency two ahead costs 0.
- Undefined: no forwarding. in_ready also drops when a source matches wb_rd with wb_v=1, so a dependency one ahead costs 2 stall cycles and two ahead costs 1. Operands always come from rf.

Test Plan:
- Reset then dbg_addr sweep 0..7 -> dbg_data=0 for all; A=B=0, alu_op=000, illegal_flag=0.
- Seed registers:
  - Preload path: r1=5, r2=3 (via preceding ADDs from r0 are impossible, so seed by a bench-forced rf or by dependent ops).
  - Issue ADD r3,r1,r2 -> alu_op=001, A=5, B=3 one edge after acceptance.
  - Two edges later, dbg r3=8.
- Dependency: ADD r3,r1,r2 immediately followed by SUB r4,r3,r1:
  - in_ready=0 for exactly 1 cycle (2 without FWD_EN); a NOP bubble is issued.
  - SUB issues with A=8, B=5; r4=3.
- Write to r0: ADD r0,r1,r2 -> r0 still reads 0; a following op reading r0 gets A=0 with no stall.
- Reserved op 110 accepted -> alu_op=000 issued, illegal_flag=1 and stays 1 until RST; no register changes.
- Assert RST one cycle after accepting ADD r5,r1,r2 -> r5 remains 0 after reset; in_ready=0 during RST and 1 the cycle after release.

Source files
------------

// File: rtl/alu_issue_if.sv
// Issue-stage bus: instruction valid/ready handshake toward the stage plus
// the registered operand/opcode bus to the ALU and its result back.
interface alu_issue_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic [15:0]   in_instr;
  logic          in_ready;
  logic [DW-1:0] alu_result;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic [2:0]    alu_op;

  modport slave (
    input  in_valid, in_instr, alu_result,
    output in_ready, A, B, alu_op
  );

  modport master (
    output in_valid, in_instr, alu_result,
    input  in_ready, A, B, alu_op
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Decode/operand-issue stage ahead of the 8-bit pipelined ALU, with RAW hazard stalls.
// Optional macro ALU_ISSUE_FWD_EN enables forwarding of alu_result from the wb slot.
module alu_issue_stage #(
  parameter int DW   = 8,
  parameter int NREG = 8
) (
  input  logic          CLK,
  input  logic          RST,
  alu_issue_if.slave    bus,
  output logic          illegal_flag,
  input  logic [2:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);
  localparam int RW = $clog2(NREG);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;

  logic [DW-1:0] rf_reg [NREG];
  logic [DW-1:0] a_reg, b_reg;
  logic [2:0]    alu_op_reg;
  logic          illegal_reg;
  logic          ex_v_reg, wb_v_reg;
  logic [RW-1:0] ex_rd_reg, wb_rd_reg;

  logic [2:0]    op;
  logic [RW-1:0] rd, rs1, rs2;
  logic          uses_rs2, writes_rd, reserved_op;
  logic          haz_ex, haz_wb, ready, accept;
  logic [DW-1:0] opnd_a, opnd_b;
  logic          unused_bits;

  assign op          = bus.in_instr[15:13];
  assign rd          = bus.in_instr[12:10];
  assign rs1         = bus.in_instr[9:7];
  assign rs2         = bus.in_instr[6:4];
  assign unused_bits = ^bus.in_instr[3:0];

  assign uses_rs2    = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  assign reserved_op = (op > OP_NOT);
  assign writes_rd   = (op != OP_NOP) && !reserved_op && (rd != '0);

  // Slots only hold writing ops with rd != 0, so r0 sources never match.
  assign haz_ex = ex_v_reg && ((rs1 == ex_rd_reg) || (uses_rs2 && (rs2 == ex_rd_reg)));

`ifdef ALU_ISSUE_FWD_EN
  assign haz_wb = 1'b0;

  always_comb begin
    opnd_a = rf_reg[rs1];
    opnd_b = rf_reg[rs2];
    if (wb_v_reg && (wb_rd_reg == rs1)) opnd_a = bus.alu_result;
    if (wb_v_reg && (wb_rd_reg == rs2)) opnd_b = bus.alu_result;
    if (op == OP_NOT) opnd_b = '0;
  end
`else
  // Without forwarding, wait until the wb slot has landed in the register file.
  assign haz_wb = wb_v_reg && ((rs1 == wb_rd_reg) || (uses_rs2 && (rs2 == wb_rd_reg)));

  always_comb begin
    opnd_a = rf_reg[rs1];
    opnd_b = (op == OP_NOT) ? '0 : rf_reg[rs2];
  end
`endif

  assign ready  = !RST && !haz_ex && !haz_wb;
  assign accept = bus.in_valid && ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_reg       <= '0;
      b_reg       <= '0;
      alu_op_reg  <= OP_NOP;
      illegal_reg <= 1'b0;
      ex_v_reg    <= 1'b0;
      ex_rd_reg   <= '0;
      wb_v_reg    <= 1'b0;
      wb_rd_reg   <= '0;
    end else begin
      wb_v_reg  <= ex_v_reg;
      wb_rd_reg <= ex_rd_reg;
      if (accept) begin
        a_reg      <= opnd_a;
        b_reg      <= opnd_b;
        alu_op_reg <= reserved_op ? OP_NOP : op;
        ex_v_reg   <= writes_rd;
        ex_rd_reg  <= rd;
        if (reserved_op) illegal_reg <= 1'b1;
      end else begin
        alu_op_reg <= OP_NOP;
        ex_v_reg   <= 1'b0;
      end
    end
  end

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) rf_reg[i] <= '0;
    end else if (wb_v_reg && (wb_rd_reg != '0)) begin
      rf_reg[wb_rd_reg] <= bus.alu_result;
    end
  end

  assign bus.in_ready = ready;
  assign bus.A        = a_reg;
  assign bus.B        = b_reg;
  assign bus.alu_op   = alu_op_reg;
  assign illegal_flag = illegal_reg;
  assign dbg_data     = rf_reg[dbg_addr];
endmodule
